// File: rtl/lfsr_checker.sv
// lfsr_checker
// Self-synchronising PRBS checker. It predicts each received bit from the
// previous WIDTH received bits using the generator polynomial. It declares lock
// after a run of good predictions. While locked it counts checked bits and
// mismatches, so software can sweep delay taps looking for the error-free eye.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_FILL    | loading the history register; no predictions are trusted yet
// ST_HUNT    | counting consecutive good predictions on a non-zero history
// ST_LOCKED  | locked; every bit is counted and mismatches pulse err
module lfsr_checker #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] POLY         = 16'hD008,
    parameter int unsigned      LOCK_COUNT   = 64,
    parameter int unsigned      UNLOCK_COUNT = 8,
    parameter int unsigned      CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             lost,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // The run counter is shared by HUNT (good streak) and LOCKED (bad streak),
    // so it is sized for the larger of the two thresholds.
    localparam int unsigned RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
    localparam int unsigned FILL_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [RUN_W-1:0]  LOCK_TC   = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0]  UNLOCK_TC = RUN_W'(UNLOCK_COUNT);
    localparam logic [FILL_W-1:0] FILL_TC   = FILL_W'(WIDTH - 1);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [WIDTH-1:0]  shreg;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_nxt;
    logic [RUN_W-1:0]  run_inc;
    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic pred;
    logic match;
    logic hist_nz;
    logic err_nxt;
    logic bit_inc;
    logic err_inc;
    logic loss;
    logic bit_sat;
    logic err_sat;

    // shreg[k] holds the bit received k+1 enabled cycles ago, the same layout as
    // the generator register, so the tap mask applies unchanged.
    assign pred    = ^(shreg & POLY);
    assign match   = (din == pred);
    assign hist_nz = |shreg;
    assign run_inc = run + 1'b1;
    assign bit_sat = &bit_cnt;
    assign err_sat = &err_cnt;

    // History register: every enabled bit is shifted in, whatever the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (ce) begin
            shreg <= {shreg[WIDTH-2:0], din};
        end
    end

    // Next-state decode for the lock FSM, including the run and fill counters.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        fill_nxt  = fill;
        err_nxt   = 1'b0;
        bit_inc   = 1'b0;
        err_inc   = 1'b0;
        loss      = 1'b0;
        if (ce) begin
            case (state)
                ST_FILL: begin
                    if (fill == FILL_TC) begin
                        state_nxt = ST_HUNT;
                        fill_nxt  = '0;
                    end else begin
                        fill_nxt = fill + 1'b1;
                    end
                end
                ST_HUNT: begin
                    // An all-zero history predicts zero and would match a dead
                    // line forever, so it never counts towards lock.
                    if (match && hist_nz) begin
                        if (run_inc == LOCK_TC) begin
                            state_nxt = ST_LOCKED;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    bit_inc = 1'b1;
                    if (!match) begin
                        err_nxt = 1'b1;
                        err_inc = 1'b1;
                        if (run_inc == UNLOCK_TC) begin
                            state_nxt = ST_HUNT;
                            run_nxt   = '0;
                            loss      = 1'b1;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                    run_nxt   = '0;
                    fill_nxt  = '0;
                end
            endcase
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
            run   <= '0;
            fill  <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            fill  <= fill_nxt;
        end
    end

    // Registered status: locked follows the next state, err is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            locked <= (state_nxt == ST_LOCKED);
            err    <= err_nxt;
        end
    end

    // Saturating bit counter; clr wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (bit_inc && !bit_sat) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Saturating error counter; clr wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (err_inc && !err_sat) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Sticky loss-of-lock flag; clr wins over a same-cycle loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost <= 1'b0;
        end else if (clr) begin
            lost <= 1'b0;
        end else if (loss) begin
            lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: scenario tasks against a bit-history reference model.
module tb_lfsr_checker;

    localparam int          W      = 16;
    localparam logic [15:0] POLY   = 16'hD008;
    localparam int          LOCK   = 64;
    localparam int          UNLOCK = 8;

    logic        clk;
    logic        rst_n;
    logic        ce, din, clr;
    logic        locked, err, lost;
    logic [31:0] bit_cnt, err_cnt;
    logic        ce4, din4, clr4;
    logic        locked4, err4, lost4;
    logic [3:0]  bit_cnt4, err_cnt4;

    int n_cmp;
    int n_bad;

    logic [15:0] gen;
    logic [15:0] g4;

    // Reference model state: a record of what the spec's rules imply.
    logic        m_locked, m_err, m_lost;
    logic [31:0] m_bit, m_errc;
    int          m_good, m_bad, m_nrx;
    logic        hist[$];

    lfsr_checker #(.WIDTH(16), .POLY(16'hD008), .LOCK_COUNT(64), .UNLOCK_COUNT(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .clr(clr),
        .locked(locked), .err(err), .lost(lost), .bit_cnt(bit_cnt), .err_cnt(err_cnt)
    );

    lfsr_checker #(.WIDTH(16), .POLY(16'hD008), .LOCK_COUNT(64), .UNLOCK_COUNT(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce4), .din(din4), .clr(clr4),
        .locked(locked4), .err(err4), .lost(lost4), .bit_cnt(bit_cnt4), .err_cnt(err_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator: Fibonacci LFSR, newest bit in r[0]; the checker sees r[15].
    function automatic logic [15:0] gstep(input logic [15:0] r);
        return {r[14:0], ^(r & POLY)};
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_err = 1'b0; m_lost = 1'b0;
        m_bit = '0; m_errc = '0;
        m_good = 0; m_bad = 0; m_nrx = 0;
        hist.delete();
        for (int k = 0; k < W; k++) hist.push_back(1'b0);
    endtask

    // One enabled/idle cycle of the reference model. hist[W-1] is the newest bit.
    task automatic model_step(input logic c, input logic d, input logic cl);
        logic p;
        logic nz;
        m_err = 1'b0;
        if (c) begin
            if (m_nrx >= W) begin
                p  = 1'b0;
                nz = 1'b0;
                for (int k = 0; k < W; k++) begin
                    if (POLY[k]) p = p ^ hist[W-1-k];
                    nz = nz | hist[W-1-k];
                end
                if (!m_locked) begin
                    m_good = (d == p && nz) ? m_good + 1 : 0;
                    if (m_good == LOCK) begin
                        m_locked = 1'b1; m_good = 0; m_bad = 0;
                    end
                end else begin
                    if (m_bit != 32'hFFFF_FFFF) m_bit = m_bit + 1;
                    if (d != p) begin
                        m_err = 1'b1;
                        if (m_errc != 32'hFFFF_FFFF) m_errc = m_errc + 1;
                        m_bad++;
                        if (m_bad == UNLOCK) begin
                            m_locked = 1'b0; m_bad = 0; m_good = 0; m_lost = 1'b1;
                        end
                    end else begin
                        m_bad = 0;
                    end
                end
            end
            hist.push_back(d);
            void'(hist.pop_front());
            m_nrx++;
        end
        if (cl) begin
            m_bit = '0; m_errc = '0; m_lost = 1'b0;
        end
    endtask

    task automatic tick(input logic c, input logic d, input logic cl);
        ce = c; din = d; clr = cl;
        @(posedge clk);
        #1;
        model_step(c, d, cl);
    endtask

    task automatic tick4(input logic c, input logic d, input logic cl);
        ce = 1'b0; ce4 = c; din4 = d; clr4 = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce = 1'b0; din = 1'b0; clr = 1'b0;
        ce4 = 1'b0; din4 = 1'b0; clr4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        gen = 16'h0001;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b0; din = 1'b0; clr = 1'b0;
        ce4 = 1'b0; din4 = 1'b0; clr4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({locked, err, lost, bit_cnt, err_cnt} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_main got=%h want=0", {locked, err, lost, bit_cnt, err_cnt});
        end
        n_cmp++;
        if ({locked4, err4, lost4, bit_cnt4, err_cnt4} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_cnt4 got=%h want=0", {locked4, err4, lost4, bit_cnt4, err_cnt4});
        end
        rst_n = 1'b1;
        model_reset();
        gen = 16'h0001;
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
            n_bad++;
            $display("FAIL idle_after_reset got=%h want=%h", {locked, err, lost, bit_cnt, err_cnt},
                     {m_locked, m_err, m_lost, m_bit, m_errc});
        end
    endtask

    task automatic test_lock();
        int k_lock;
        int n_errp;
        k_lock = 0;
        for (int k = 1; k <= 200 && k_lock == 0; k++) begin
            tick(1'b1, gen[15], 1'b0);
            gen = gstep(gen);
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL lock_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
            if (locked === 1'b1) k_lock = k;
        end
        n_cmp++;
        if (k_lock !== 80) begin
            n_bad++;
            $display("FAIL lock_latency got=%0d want=80", k_lock);
        end
        n_errp = 0;
        repeat (10000) begin
            tick(1'b1, gen[15], 1'b0);
            gen = gstep(gen);
            if (err !== 1'b0) n_errp++;
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL clean_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
        end
        n_cmp++;
        if (n_errp !== 0) begin
            n_bad++;
            $display("FAIL clean_err_pulses got=%0d want=0", n_errp);
        end
        n_cmp++;
        if (bit_cnt !== 32'd10000) begin
            n_bad++;
            $display("FAIL clean_bit_cnt got=%0d want=10000", bit_cnt);
        end
    endtask

    task automatic test_single_flip();
        int offs[$];
        int exp_offs[5] = '{0, 4, 13, 15, 16};
        tick(1'b1, gen[15], 1'b1);
        gen = gstep(gen);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, gen[15] ^ (i == 0), 1'b0);
            gen = gstep(gen);
            if (err === 1'b1) offs.push_back(i);
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL flip_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
        end
        n_cmp++;
        if (offs.size() !== 5) begin
            n_bad++;
            $display("FAIL flip_pulse_count got=%0d want=5", offs.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                n_cmp++;
                if (offs[j] !== exp_offs[j]) begin
                    n_bad++;
                    $display("FAIL flip_offset[%0d] got=%0d want=%0d", j, offs[j], exp_offs[j]);
                end
            end
        end
        n_cmp++;
        if (err_cnt !== 32'd5) begin
            n_bad++;
            $display("FAIL flip_err_cnt got=%0d want=5", err_cnt);
        end
        n_cmp++;
        if (locked !== 1'b1 || lost !== 1'b0) begin
            n_bad++;
            $display("FAIL flip_still_locked got=%b/%b want=1/0", locked, lost);
        end
    endtask

    task automatic test_stuck_zero();
        int n_lk;
        do_reset();
        n_lk = 0;
        repeat (1000) begin
            tick(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) n_lk++;
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL stuck_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
        end
        n_cmp++;
        if (n_lk !== 0) begin
            n_bad++;
            $display("FAIL stuck_locked_cycles got=%0d want=0", n_lk);
        end
        n_cmp++;
        if (bit_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL stuck_bit_cnt got=%0d want=0", bit_cnt);
        end
    endtask

    task automatic test_loss_relock();
        int n_rand;
        int k_re;
        do_reset();
        repeat (130) begin
            tick(1'b1, gen[15], 1'b0);
            gen = gstep(gen);
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_prelock got=%b want=1", locked);
        end
        n_rand = 0;
        while (m_locked && n_rand < 20000) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            gen = gstep(gen);
            n_rand++;
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL random_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
        end
        n_cmp++;
        if (locked !== 1'b0 || lost !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_flags got=%b/%b want=0/1 after %0d random bits", locked, lost, n_rand);
        end
        k_re = 0;
        for (int k = 1; k <= 100 && k_re == 0; k++) begin
            tick(1'b1, gen[15], 1'b0);
            gen = gstep(gen);
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL relock_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
            if (locked === 1'b1) k_re = k;
        end
        n_cmp++;
        if (k_re < 64 || k_re > 80) begin
            n_bad++;
            $display("FAIL relock_latency got=%0d want=64..80", k_re);
        end
    endtask

    task automatic test_ce_gaps();
        int   n_ce;
        int   k_lock;
        int   n_lk;
        logic c;
        logic d;
        do_reset();
        n_ce = 0;
        k_lock = 0;
        for (int i = 0; i < 2000 && k_lock == 0; i++) begin
            c = ($urandom_range(0, 99) < 60);
            d = c ? gen[15] : 1'($urandom_range(0, 1));
            tick(c, d, 1'b0);
            if (c) begin
                gen = gstep(gen);
                n_ce++;
            end
            n_cmp++;
            if ({locked, err, lost, bit_cnt, err_cnt} !== {m_locked, m_err, m_lost, m_bit, m_errc}) begin
                n_bad++;
                $display("FAIL gap_lock_model t=%0t got=%h want=%h", $time, {locked, err, lost, bit_cnt, err_cnt},
                         {m_locked, m_err, m_lost, m_bit, m_errc});
            end
            if (locked === 1'b1) k_lock = n_ce;
        end
        n_cmp++;
        if (k_lock !== 80) begin
            n_bad++;
            $display("FAIL gap_lock_bits got=%0d want=80", k_lock);
        end
        n_lk = 0;
        repeat (2000) begin
            c = ($urandom_range(0, 99) < 50);
            d = c ? gen[15] : 1'($urandom_range(0, 1));
            tick(c, d, 1'b0);
            if (c) begin
                gen = gstep(gen);
                n_lk++;
            end
        end
        n_cmp++;
        if (bit_cnt !== 32'(n_lk)) begin
            n_bad++;
            $display("FAIL gap_bit_cnt got=%0d want=%0d", bit_cnt, n_lk);
        end
        n_cmp++;
        if (err_cnt !== 32'd0 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_status got err_cnt=%0d locked=%b want 0/1", err_cnt, locked);
        end
    endtask

    task automatic test_sat_clr_rst();
        int k4;
        g4 = 16'h0001;
        k4 = 0;
        for (int k = 1; k <= 200 && k4 == 0; k++) begin
            tick4(1'b1, g4[15], 1'b0);
            g4 = gstep(g4);
            if (locked4 === 1'b1) k4 = k;
        end
        n_cmp++;
        if (k4 !== 80) begin
            n_bad++;
            $display("FAIL sat_lock_latency got=%0d want=80", k4);
        end
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 40; i++) begin
                tick4(1'b1, g4[15] ^ (i == 0), 1'b0);
                g4 = gstep(g4);
            end
        end
        n_cmp++;
        if (err_cnt4 !== 4'd15 || bit_cnt4 !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_counts got err=%0d bit=%0d want 15/15", err_cnt4, bit_cnt4);
        end
        n_cmp++;
        if (locked4 !== 1'b1 || lost4 !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_lock_state got=%b/%b want=1/0", locked4, lost4);
        end
        tick4(1'b1, ~g4[15], 1'b1);
        g4 = gstep(g4);
        n_cmp++;
        if (err_cnt4 !== 4'd0 || err4 !== 1'b1 || bit_cnt4 !== 4'd0) begin
            n_bad++;
            $display("FAIL clr_vs_err got err_cnt=%0d err=%b bit_cnt=%0d want 0/1/0", err_cnt4, err4, bit_cnt4);
        end
        repeat (20) begin
            tick4(1'b1, g4[15], 1'b0);
            g4 = gstep(g4);
        end
        n_cmp++;
        if (err_cnt4 !== 4'd4) begin
            n_bad++;
            $display("FAIL clr_followup_err_cnt got=%0d want=4", err_cnt4);
        end
        ce4 = 1'b1; din4 = g4[15];
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({locked4, err4, lost4, bit_cnt4, err_cnt4} !== 11'd0) begin
            n_bad++;
            $display("FAIL async_reset_cnt4 got=%h want=0", {locked4, err4, lost4, bit_cnt4, err_cnt4});
        end
        n_cmp++;
        if ({locked, err, lost, bit_cnt, err_cnt} !== 67'd0) begin
            n_bad++;
            $display("FAIL async_reset_main got=%h want=0", {locked, err, lost, bit_cnt, err_cnt});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        g4 = 16'h0001;
        k4 = 0;
        for (int k = 1; k <= 200 && k4 == 0; k++) begin
            tick4(1'b1, g4[15], 1'b0);
            g4 = gstep(g4);
            if (locked4 === 1'b1) k4 = k;
        end
        n_cmp++;
        if (k4 !== 80) begin
            n_bad++;
            $display("FAIL refill_lock_latency got=%0d want=80", k4);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lock();
        test_single_flip();
        test_stuck_zero();
        test_loss_relock();
        test_ce_gaps();
        test_sat_clr_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
